// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that time-shares one single-precision multiplier among
// NUM_REQ requesters and returns tagged results, with a watchdog on mul_done_i.
module fp_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic [NUM_REQ*32-1:0]   req_a_i,
   input  logic [NUM_REQ*32-1:0]   req_b_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [ID_W-1:0]         rsp_id_o,
   output logic [31:0]             rsp_product_o,
   output logic [4:0]              rsp_flags_o,
   output logic                    mul_start_o,
   output logic [31:0]             mul_a_o,
   output logic [31:0]             mul_b_o,
   input  logic                    mul_done_i,
   input  logic                    mul_nan_i,
   input  logic                    mul_inf_i,
   input  logic                    mul_ovf_i,
   input  logic                    mul_unf_i,
   input  logic [31:0]             mul_product_i,
   output logic                    busy_o
);

   localparam int                CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0]       QNAN     = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e              state_q;
   logic [ID_W-1:0]     ptr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                done_q;
   logic                mul_start_q;
   logic [31:0]         mul_a_q;
   logic [31:0]         mul_b_q;
   logic                rsp_valid_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic [31:0]         rsp_product_q;
   logic [4:0]          rsp_flags_q;
   logic                busy_q;

   logic                grant_vld_s;
   logic [ID_W-1:0]     grant_id_s;
   logic [ID_W-1:0]     idx_s;
   logic [ID_W:0]       scan_s;
   logic [NUM_REQ-1:0]  grant_oh_s;
   logic [31:0]         grant_a_s;
   logic [31:0]         grant_b_s;

   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
      next_ptr = (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
   endfunction

   // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = '0;
      scan_s      = '0;
      idx_s       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_s = {1'b0, ptr_q} + (ID_W+1)'(i);
         idx_s  = (scan_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(scan_s - (ID_W+1)'(NUM_REQ))
                                                 : scan_s[ID_W-1:0];
         if (!grant_vld_s && req_valid_i[idx_s]) begin
            grant_vld_s = 1'b1;
            grant_id_s  = idx_s;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // One-hot decode of the grant and operand selection.
   always_comb begin
      grant_oh_s = '0;
      grant_a_s  = '0;
      grant_b_s  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_vld_s && (grant_id_s == ID_W'(k))) begin
            grant_oh_s[k] = 1'b1;
            grant_a_s     = req_a_i[32*k +: 32];
            grant_b_s     = req_b_i[32*k +: 32];
         end else begin
            grant_oh_s[k] = 1'b0;
         end
      end
   end

   assign req_ready_o   = (state_q == S_IDLE) ? grant_oh_s : '0;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_id_o      = rsp_id_q;
   assign rsp_product_o = rsp_product_q;
   assign rsp_flags_o   = rsp_flags_q;
   assign mul_start_o   = mul_start_q;
   assign mul_a_o       = mul_a_q;
   assign mul_b_o       = mul_b_q;
   assign busy_o        = busy_q;

   // Scheduler FSM with registered outputs; done edge qualified against done_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         done_q        <= 1'b0;
         mul_start_q   <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_product_q <= '0;
         rsp_flags_q   <= '0;
         busy_q        <= 1'b0;
      end else begin
         done_q <= mul_done_i;
         case (state_q)
            S_IDLE: begin
               if (grant_vld_s) begin
                  mul_a_q     <= grant_a_s;
                  mul_b_q     <= grant_b_s;
                  rsp_id_q    <= grant_id_s;
                  mul_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mul_start_q <= 1'b0;
               cnt_q       <= '0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               if (mul_done_i && !done_q) begin
                  rsp_product_q <= mul_product_i;
                  rsp_flags_q   <= {1'b0, mul_unf_i, mul_ovf_i, mul_inf_i, mul_nan_i};
                  rsp_valid_q   <= 1'b1;
                  state_q       <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_product_q <= QNAN;
                  rsp_flags_q   <= 5'b10001;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  ptr_q       <= next_ptr(rsp_id_q);
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               mul_start_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Round-robin scheduler that shares one multiplier32FP instance among NUM_REQ requesters. It accepts one operand pair at a time and drives the multiplier's start/done handshake. It returns the product and exception flags to the granted requester over a shared, tagged response channel. A watchdog releases the unit if done never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester tag; must equal clog2(NUM_REQ)
TIMEOUT, 64, cycles to wait for mul_done_i before aborting (>=4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester operand valid
req_ready_o  out  NUM_REQ  per-requester accept, one-hot or zero
req_a_i  in  NUM_REQ*32  operand A, requester k at bits [32k+31:32k]
req_b_i  in  NUM_REQ*32  operand B, same packing
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumer ready
rsp_id_o  out  ID_W  index of requester owning the response
rsp_product_o  out  32  IEEE-754 single product
rsp_flags_o  out  5  {timeout, underflow, overflow, infinite, nan}
mul_start_o  out  1  start pulse to multiplier
mul_a_o  out  32  multiplier operand A
mul_b_o  out  32  multiplier operand B
mul_done_i  in  1  multiplier done
mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i  in  1 each  multiplier flags
mul_product_i  in  32  multiplier result
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, pointer=0, all outputs 0 (rsp_product_o, mul_a_o, mul_b_o, rsp_flags_o, rsp_id_o = 0), timeout counter=0, done_q=0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant = first asserted req_valid_i[k] searching from pointer upward, modulo NUM_REQ.
  - req_ready_o[grant]=1 combinationally in the same cycle. Handshake completes there.
  - Latch the operands into mul_a_o/mul_b_o and the grant into rsp_id_o. Go to ISSUE.
  - No valid request: stay in IDLE, req_ready_o=0.
- ISSUE: mul_start_o=1 for exactly this one cycle. Counter cleared. Go to WAIT.
- mul_a_o and mul_b_o are held stable from ISSUE until the next grant.
- req_ready_o is all-zero outside IDLE.
- WAIT:
  - done_q is mul_done_i registered. Completion is the rising edge: mul_done_i=1 and done_q=0.
  - A done level already high on entry is not accepted. Its rising edge must occur after the start pulse.
  - On completion: capture mul_product_i and the flags, timeout bit=0. Go to RESP.
  - Else increment counter. When counter reaches TIMEOUT-1: product=32'h7FC00000 (quiet NaN), flags=5'b10001. Go to RESP.
- RESP:
  - rsp_valid_o=1, held with stable data until rsp_ready_i=1.
  - On the handshake cycle: pointer=(rsp_id_o+1) mod NUM_REQ. Go to IDLE.
- Latency: an accept at cycle T gives mul_start_o at T+1. A done edge seen at cycle D gives rsp_valid_o at D+1.
- Minimum issue interval: 4 cycles when the multiplier and rsp_ready_i respond immediately.
- A requester dropping req_valid_i outside IDLE has no effect. An accepted operation always completes.
- mul_done_i pulses outside WAIT are ignored. done_q is still updated every cycle.
- Reset mid-operation aborts immediately with no response. The multiplier is not stalled by this block.
- Fairness: after requester k is served it has lowest priority. With all requesters valid, service order is 0,1,2,3,0,...

Test Plan:
- Single request: req 1 sends a=3F800000, b=40000000, multiplier model done 5 cycles after start -> one start pulse, rsp_id=1, product 40000000, flags 0, rsp_valid 7 cycles after accept.
- All 4 requesters valid continuously with distinct operand pairs -> grant order 0,1,2,3,0,1; each rsp_id matches its requester and its expected product.
- Backpressure: rsp_ready_i low for 10 cycles in RESP -> rsp_valid and data held stable; no req_ready asserted and no new start pulse until the handshake.
- Flags: model returns nan=1 with product 7FC00000, then ovf=1 with product 7F800000 -> rsp_flags 5'b00001, then 5'b00100.
- Timeout: model never raises done, TIMEOUT=64 -> response after 64 WAIT cycles with product 7FC00000, flags 5'b10001; the next request is served normally.
- Async reset asserted in WAIT -> all outputs 0 immediately, state IDLE, pointer 0; a stale done edge arriving after reset produces no response.
